// File: rtl/tcb_pkg.sv
// Shared TCB types for the response-path register slice.
// Optional feature macro: TCB_REGISTER_RESPONSE_HOLD_EN (selects per-group byte hold).
package tcb_pkg;

    // Largest byte-enable width the tracker entry can carry; upper bits stay zero.
    localparam int unsigned TCB_BEN_MAX = 64;

    typedef struct packed {
        logic                   trn;
        logic                   wen;
        logic [TCB_BEN_MAX-1:0] ben;
    } tcb_rsp_trk_t;

    // Group enable seen by byte idx: set when any ben bit of its GRN-byte group is set.
    function automatic logic tcb_grp_en(
        input logic [TCB_BEN_MAX-1:0] ben,
        input int unsigned            idx,
        input int unsigned            grn
    );
        logic        en;
        int unsigned base;
        en   = 1'b0;
        base = (idx / grn) * grn;
        for (int unsigned j = 0; j < TCB_BEN_MAX; j++) begin
            if ((j >= base) && (j < base + grn)) begin
                en = en | ben[j];
            end
        end
        return en;
    endfunction

endpackage

// File: rtl/tcb_lib_response_tracker.sv
// DLY-deep shift register tracking which cycles carry a manager-side response.
// Output is the tail entry; DLY=0 degenerates to a combinational bypass.
module tcb_lib_response_tracker #(
    parameter int unsigned W   = 1,
    parameter int unsigned DLY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DLY == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [W-1:0] sr [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned i = 0; i < DLY; i++) begin
                    sr[i] <= '0;
                end
            end else begin
                sr[0] <= din;
                for (int unsigned i = 1; i < DLY; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign dout = sr[DLY-1];
    end

endmodule

// File: rtl/tcb_lib_register_response.sv
// TCB response-path register slice: request passes through, rdt/err are registered.
// Optional feature macro: TCB_REGISTER_RESPONSE_HOLD_EN (per-group byte hold on reads).
module tcb_lib_register_response
    import tcb_pkg::*;
#(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned SLW = 8,
    parameter int unsigned BEW = DBW / SLW,
    parameter int unsigned DLY = 1,
    parameter int unsigned GRN = 1
) (
    input  logic           clk,
    input  logic           rst,
    // subordinate side (upstream)
    input  logic           sub_vld,
    input  logic           sub_wen,
    input  logic [ABW-1:0] sub_adr,
    input  logic [BEW-1:0] sub_ben,
    input  logic [DBW-1:0] sub_wdt,
    output logic           sub_rdy,
    output logic [DBW-1:0] sub_rdt,
    output logic           sub_err,
    // manager side (downstream)
    output logic           man_vld,
    output logic           man_wen,
    output logic [ABW-1:0] man_adr,
    output logic [BEW-1:0] man_ben,
    output logic [DBW-1:0] man_wdt,
    input  logic           man_rdy,
    input  logic [DBW-1:0] man_rdt,
    input  logic           man_err
);

    if ((GRN == 0) || (BEW % GRN != 0)) begin : g_chk_grn
        $error("tcb_lib_register_response: GRN=%0d must divide BEW=%0d", GRN, BEW);
    end
    if (BEW * SLW != DBW) begin : g_chk_dbw
        $error("tcb_lib_register_response: DBW=%0d must equal BEW*SLW", DBW);
    end
    if (BEW > TCB_BEN_MAX) begin : g_chk_bew
        $error("tcb_lib_register_response: BEW=%0d exceeds tracker capacity", BEW);
    end

    assign man_vld = sub_vld;
    assign man_wen = sub_wen;
    assign man_adr = sub_adr;
    assign man_ben = sub_ben;
    assign man_wdt = sub_wdt;
    assign sub_rdy = man_rdy;

    logic trn;
    logic rsp;

    assign trn = man_vld & man_rdy;

`ifdef TCB_REGISTER_RESPONSE_HOLD_EN
    tcb_rsp_trk_t trk_in;
    tcb_rsp_trk_t trk_out;

    always_comb begin
        trk_in              = '0;
        trk_in.trn          = trn;
        trk_in.wen          = man_wen;
        trk_in.ben[BEW-1:0] = man_ben;
    end

    tcb_lib_response_tracker #(
        .W   ($bits(tcb_rsp_trk_t)),
        .DLY (DLY)
    ) u_trk (
        .clk  (clk),
        .rst  (rst),
        .din  (trk_in),
        .dout (trk_out)
    );

    assign rsp = trk_out.trn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_rdt <= '0;
            sub_err <= 1'b0;
        end else if (rsp) begin
            sub_err <= man_err;
            for (int unsigned i = 0; i < BEW; i++) begin
                if (!trk_out.wen && tcb_grp_en(trk_out.ben, i, GRN)) begin
                    sub_rdt[i*SLW +: SLW] <= man_rdt[i*SLW +: SLW];
                end
            end
        end
    end
`else
    logic trk_out;

    tcb_lib_response_tracker #(
        .W   (1),
        .DLY (DLY)
    ) u_trk (
        .clk  (clk),
        .rst  (rst),
        .din  (trn),
        .dout (trk_out)
    );

    assign rsp = trk_out;

    // Without byte tracking every response reloads the whole word, writes included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_rdt <= '0;
            sub_err <= 1'b0;
        end else if (rsp) begin
            sub_err <= man_err;
            sub_rdt <= man_rdt;
        end
    end
`endif

endmodule
